load_store_unit: RTL and testbench

Multi-cycle memory access sequencer between the execute stage and the data-memory port. It accepts one load or store per request and enforces natural alignment. It drives a req/ready handshake to memory with byte enables and lane-replicated write data. For loads it extracts the addressed byte, halfword or word and sign- or zero-extends it to 32 bits, the same extension rule the immediate path uses.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store sequencer: checks alignment and opcode, runs one req/ready access
// to data memory, and sign/zero-extends load data into a held result register.
`timescale 1ns/1ps
module load_store_unit #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        start,
    input  logic        isStore,
    input  logic [2:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  errCause,
    output logic [31:0] rdata,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [3:0]  memBe,
    output logic [31:0] memWdata,
    input  logic [31:0] memRdata,
    input  logic        memReady
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, FAIL} state_e;

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);
    localparam logic [1:0] SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b11;
    localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_MISALIGN = 2'b01,
                           CAUSE_TIMEOUT = 2'b10, CAUSE_ILLEGAL = 2'b11;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  wait_q, wait_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] rdata_q, rdata_d;

    logic        req_illegal, req_misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, load_ext;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Request checks act on the live inputs so the verdict is known on the start edge.
    always_comb begin
        req_illegal    = isStore ? (memOp[1:0] == 2'b10)
                                 : (memOp inside {3'b010, 3'b110, 3'b111});
        req_misaligned = ((memOp[1:0] == SZ_HALF) && addr[0]) ||
                         ((memOp[1:0] == SZ_WORD) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        byte_lane = memRdata[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? memRdata[31:16] : memRdata[15:0];
        case (op_q[1:0])
            SZ_BYTE: begin
                lane_be    = 4'b0001 << addr_q[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
                load_ext   = op_q[2] ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                lane_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                load_ext   = op_q[2] ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
            end
            default: begin
                lane_be    = 4'b1111;
                lane_wdata = wdata_q;
                load_ext   = memRdata;
            end
        endcase
    end

    // NOTE: every variable below gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_d     = wait_q;
        cause_d    = cause_q;
        rdata_d    = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d = isStore;
                    op_d       = memOp;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    wait_d     = 8'd0;
                    if (req_illegal) begin
                        cause_d = CAUSE_ILLEGAL;
                        state_d = FAIL;
                    end else if (req_misaligned) begin
                        cause_d = CAUSE_MISALIGN;
                        state_d = FAIL;
                    end else begin
                        cause_d = CAUSE_NONE;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (memReady) begin
                    if (!is_store_q) rdata_d = load_ext;
                    state_d = DONE;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == WAIT_LIMIT) begin
                        cause_d = CAUSE_TIMEOUT;
                        state_d = FAIL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the latched request
    // fields are plain flops (not a memory), so resetting them all is cheap and safe.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            op_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wait_q     <= 8'd0;
            cause_q    <= CAUSE_NONE;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_q     <= wait_d;
            cause_q    <= cause_d;
            rdata_q    <= rdata_d;
        end
    end

    // Memory-side outputs decode straight from state so reset drops memReq at once.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE) || (state_q == FAIL);
        err      = (state_q == FAIL);
        errCause = (state_q == FAIL) ? cause_q : CAUSE_NONE;
        rdata    = rdata_q;
        memReq   = (state_q == REQ);
        memWe    = memReq && is_store_q;
        memAddr  = memReq ? {addr_q[31:2], 2'b00} : 32'h0;
        memBe    = memReq ? lane_be : 4'b0000;
        memWdata = memReq ? lane_wdata : 32'h0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, error paths, timeout,
// ignored start while busy and asynchronous reset mid-access.
`timescale 1ns/1ps
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start, isStore;
    logic [2:0]  memOp;
    logic [31:0] addr, wdata;
    logic        busy, done, err;
    logic [1:0]  errCause;
    logic [31:0] rdata;
    logic        memReq, memWe;
    logic [31:0] memAddr;
    logic [3:0]  memBe;
    logic [31:0] memWdata;
    logic [31:0] memRdata;
    logic        memReady;

    int passed = 0;
    int total  = 0;

    load_store_unit #(.WAIT_MAX(15)) dut (
        .clk(clk), .rstN(rstN), .start(start), .isStore(isStore), .memOp(memOp),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .errCause(errCause), .rdata(rdata), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memBe(memBe), .memWdata(memWdata),
        .memRdata(memRdata), .memReady(memReady)
    );

    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of cycle 1 (start seen in cycle 0).
    task automatic issue(input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] wd);
        isStore = st; memOp = op; addr = a; wdata = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; start = 1'b0; isStore = 1'b0; memOp = 3'b000;
        addr = 32'h0; wdata = 32'h0; memRdata = 32'h0; memReady = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, err, errCause, memReq, memWe, memBe} !== 10'b0 ||
            rdata !== 32'h0 || memAddr !== 32'h0 || memWdata !== 32'h0)
            $display("FAIL reset: busy=%b done=%b err=%b cause=%b req=%b we=%b be=%b rdata=%h addr=%h wd=%h exp all zero",
                     busy, done, err, errCause, memReq, memWe, memBe, rdata, memAddr, memWdata);
        else passed++;
        rstN = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_byte_load();
        memRdata = 32'hAB12_3456; memReady = 1'b1;
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        total++;
        if ({memReq, memWe, memBe, done} !== {1'b1, 1'b0, 4'b1000, 1'b0} || memAddr !== 32'h100)
            $display("FAIL lb_req: req=%b we=%b be=%b done=%b addr=%h exp 1 0 1000 0 00000100",
                     memReq, memWe, memBe, done, memAddr);
        else passed++;
        @(negedge clk); memReady = 1'b0;
        total++;
        if ({done, err, errCause} !== 4'b1000 || rdata !== 32'hFFFF_FFAB)
            $display("FAIL lb_done: done=%b err=%b cause=%b rdata=%h exp 1 0 00 ffffffab",
                     done, err, errCause, rdata);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00)
            $display("FAIL lb_idle: done=%b busy=%b exp 0 0", done, busy);
        else passed++;
        // Back-to-back: start accepted in the first IDLE cycle after done.
        memReady = 1'b1;
        issue(1'b0, 3'b100, 32'h103, 32'h0);
        total++;
        if (memReq !== 1'b1)
            $display("FAIL b2b_accept: memReq=%b exp 1", memReq);
        else passed++;
        @(negedge clk); memReady = 1'b0;
        total++;
        if ({done, err} !== 2'b10 || rdata !== 32'h0000_00AB)
            $display("FAIL lbu_done: done=%b err=%b rdata=%h exp 1 0 000000ab", done, err, rdata);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_half_load(input logic [2:0] op, input logic [31:0] exp_rdata,
                                  input logic [31:0] prev_rdata);
        memRdata = 32'h8001_7FFF; memReady = 1'b0;
        issue(1'b0, op, 32'h202, 32'h0);
        total++;
        if ({memReq, memBe} !== 5'b11100 || memAddr !== 32'h200)
            $display("FAIL lh_req op=%b: req=%b be=%b addr=%h exp 1 1100 00000200", op, memReq, memBe, memAddr);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if ({memReq, memBe, done} !== 6'b111000 || rdata !== prev_rdata)
            $display("FAIL lh_wait op=%b: req=%b be=%b done=%b rdata=%h exp 1 1100 0 %h",
                     op, memReq, memBe, done, rdata, prev_rdata);
        else passed++;
        memReady = 1'b1;
        @(negedge clk); memReady = 1'b0;
        total++;
        if ({done, err, errCause} !== 4'b1000 || rdata !== exp_rdata)
            $display("FAIL lh_done op=%b: done=%b err=%b cause=%b rdata=%h exp 1 0 00 %h",
                     op, done, err, errCause, rdata, exp_rdata);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_store(input logic [2:0] op, input logic [31:0] a,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd);
        memReady = 1'b1;
        issue(1'b1, op, a, 32'h1234_56CD);
        total++;
        if ({memReq, memWe, memBe} !== {2'b11, exp_be} || memWdata !== exp_wd || memAddr !== 32'h0)
            $display("FAIL store_req op=%b: req=%b we=%b be=%b wd=%h addr=%h exp 1 1 %b %h 00000000",
                     op, memReq, memWe, memBe, memWdata, memAddr, exp_be, exp_wd);
        else passed++;
        @(negedge clk); memReady = 1'b0;
        total++;
        if ({done, err} !== 2'b10 || rdata !== 32'h0000_8001)
            $display("FAIL store_done op=%b: done=%b err=%b rdata=%h exp 1 0 00008001", op, done, err, rdata);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_check_fail(input string name, input logic st, input logic [2:0] op,
                                   input logic [31:0] a, input logic [1:0] exp_cause);
        memReady = 1'b1;
        issue(st, op, a, 32'h0);
        total++;
        if ({done, err, errCause, memReq} !== {2'b11, exp_cause, 1'b0} || rdata !== 32'h0000_8001)
            $display("FAIL %s: done=%b err=%b cause=%b req=%b rdata=%h exp 1 1 %b 0 00008001",
                     name, done, err, errCause, memReq, rdata, exp_cause);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, busy, memReq} !== 3'b000)
            $display("FAIL %s_after: done=%b busy=%b req=%b exp 0 0 0", name, done, busy, memReq);
        else passed++;
        memReady = 1'b0;
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        int done_cycle = 0;
        memReady = 1'b0;
        issue(1'b0, 3'b011, 32'h40, 32'h0);
        for (int c = 1; c <= 40; c++) begin
            if (memReq) req_cycles++;
            if (done) begin
                done_cycle = c;
                total++;
                if ({err, errCause} !== 3'b110)
                    $display("FAIL timeout_cause: err=%b cause=%b exp 1 10", err, errCause);
                else passed++;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (req_cycles != 15 || done_cycle != 16)
            $display("FAIL timeout_len: memReq cycles=%0d done cycle=%0d exp 15 16", req_cycles, done_cycle);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_start_while_busy();
        int dones = 0;
        memRdata = 32'h0000_00F0; memReady = 1'b0;
        issue(1'b0, 3'b100, 32'h0, 32'h0);
        isStore = 1'b1; memOp = 3'b011; addr = 32'h3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({memReq, memWe, memBe} !== 6'b100001 || memAddr !== 32'h0)
            $display("FAIL busy_start: req=%b we=%b be=%b addr=%h exp 1 0 0001 00000000",
                     memReq, memWe, memBe, memAddr);
        else passed++;
        memReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            memReady = 1'b0;
            if (done) dones++;
        end
        total++;
        if (dones != 1 || busy !== 1'b0 || rdata !== 32'h0000_00F0)
            $display("FAIL busy_one_done: dones=%0d busy=%b rdata=%h exp 1 0 000000f0", dones, busy, rdata);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        int dones = 0;
        memReady = 1'b0;
        issue(1'b0, 3'b011, 32'h80, 32'h0);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        total++;
        if ({memReq, busy} !== 2'b00)
            $display("FAIL rst_async: memReq=%b busy=%b exp 0 0", memReq, busy);
        else passed++;
        @(negedge clk);
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        total++;
        if (dones != 0 || {busy, err, errCause, memReq, memWe, memBe} !== 9'b0 ||
            rdata !== 32'h0 || memAddr !== 32'h0 || memWdata !== 32'h0)
            $display("FAIL rst_outputs: dones=%0d busy=%b err=%b cause=%b req=%b we=%b be=%b rdata=%h exp none/all zero",
                     dones, busy, err, errCause, memReq, memWe, memBe, rdata);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_byte_load();
        test_half_load(3'b001, 32'hFFFF_8001, 32'h0000_00AB);
        test_half_load(3'b101, 32'h0000_8001, 32'hFFFF_8001);
        test_store(3'b000, 32'h1, 4'b0010, 32'hCDCD_CDCD);
        test_store(3'b001, 32'h2, 4'b1100, 32'h56CD_56CD);
        test_check_fail("lw_misaligned", 1'b0, 3'b011, 32'h6, 2'b01);
        test_check_fail("illegal_110", 1'b0, 3'b110, 32'h0, 2'b11);
        test_check_fail("illegal_priority", 1'b0, 3'b111, 32'h3, 2'b11);
        test_check_fail("sh_misaligned", 1'b1, 3'b001, 32'h5, 2'b01);
        test_check_fail("store_size10", 1'b1, 3'b110, 32'h0, 2'b11);
        test_timeout();
        test_start_while_busy();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
